// File: rtl/glm_store.sv
`timescale 1ns/1ps
// glm_store: GLM write-back engine.
// Reads a contiguous range of cache lines from a region BRAM (fixed 2-cycle
// read latency), stages them in a small FIFO and streams them to DRAM over the
// DMA write channel. op_done pulses once every written line has been acked.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset (registered once)
//   op_start_i / op_done_o    start pulse (honoured in IDLE) / completion pulse
//   in_trigger_dma_i          1: issue a DMA start before writing
//   regs_i[0..2]              region start line / DRAM line offset / {multiline, length}
//   in_addr_i                 DRAM base line address
//   dma_ctrl_*                DMA control: start, addr, reg4, async
//   dma_status_idle_i/active_i DMA status
//   dma_we_o/wdata_o/wlength_o write beats; dma_almostfull_i backpressure
//   dma_wack_i                one write acknowledge per cycle
//   region_re_o/raddr_o       region read request; region_rdata_i/rvalid_i response
//
// state   | meaning
// IDLE    | waiting for op_start
// TRIGGER | waiting for DMA idle, then pulse control.start
// WRITE   | issue region reads, pop staged lines into DMA write beats
// DRAIN   | all beats sent, waiting for remaining acks
// DONE    | pulse op_done, back to IDLE
module glm_store #(
    parameter int LOG2_MEMORY_SIZE = 10,
    parameter int LOG2_STAGE_SIZE  = 4,
    parameter int CLADDR_W         = 58
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        op_start_i,
    output logic                        op_done_o,
    input  logic                        in_trigger_dma_i,
    input  logic [31:0]                 regs_i [3],
    input  logic [CLADDR_W-1:0]         in_addr_i,
    output logic                        dma_ctrl_start_o,
    output logic [CLADDR_W-1:0]         dma_ctrl_addr_o,
    output logic [31:0]                 dma_ctrl_reg4_o,
    output logic                        dma_ctrl_async_o,
    input  logic                        dma_status_idle_i,
    input  logic                        dma_status_active_i,
    output logic                        dma_we_o,
    output logic [511:0]                dma_wdata_o,
    output logic [1:0]                  dma_wlength_o,
    input  logic                        dma_almostfull_i,
    input  logic                        dma_wack_i,
    output logic                        region_re_o,
    output logic [LOG2_MEMORY_SIZE-1:0] region_raddr_o,
    input  logic [511:0]                region_rdata_i,
    input  logic                        region_rvalid_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIGGER = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int              SW          = LOG2_STAGE_SIZE + 1;
    localparam logic [SW-1:0]   STAGE_DEPTH = {1'b1, {LOG2_STAGE_SIZE{1'b0}}};
    localparam logic [SW-1:0]   BURST_LINES = SW'(4);

    logic                        internal_reset_q;

    logic [2:0]                  state_q, state_d;
    logic [LOG2_MEMORY_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [CLADDR_W-1:0]         dram_addr_q, dram_addr_d;
    logic [30:0]                 length_q, length_d;
    logic                        multiline_q, multiline_d;
    logic [31:0]                 num_read_issued_q, num_read_issued_d;
    logic [31:0]                 num_written_q, num_written_d;
    logic [31:0]                 num_acked_q, num_acked_d;
    logic [SW-1:0]               inflight_q, inflight_d;
    logic [SW-1:0]               stage_cnt_q, stage_cnt_d;
    logic [LOG2_STAGE_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2_STAGE_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]                  burst_left_q, burst_left_d;

    logic                        op_done_q, op_done_d;
    logic                        re_q, re_d;
    logic [LOG2_MEMORY_SIZE-1:0] raddr_q, raddr_d;
    logic                        we_q, we_d;
    logic [511:0]                wdata_q, wdata_d;
    logic [1:0]                  wlength_q, wlength_d;
    logic                        ctrl_start_q, ctrl_start_d;
    logic [CLADDR_W-1:0]         ctrl_addr_q, ctrl_addr_d;
    logic [31:0]                 ctrl_reg4_q, ctrl_reg4_d;

    logic [511:0]                fifo_mem_q [2**LOG2_STAGE_SIZE];

    logic                        push, pop;
    logic [31:0]                 length_full;
    logic [31:0]                 remaining;
    logic [SW:0]                 credit_used;
    logic                        unused_regs_bits;

    assign length_full = {1'b0, length_q};
    assign remaining   = length_full - num_written_q;
    // Registered counts: a pop in this cycle is not yet credited, so the
    // check is conservative and the staging FIFO can never overflow.
    assign credit_used = {1'b0, inflight_q} + {1'b0, stage_cnt_q};
    assign push        = region_rvalid_i;
    assign unused_regs_bits = ^regs_i[0][31:LOG2_MEMORY_SIZE];

    always_comb begin
        state_d           = state_q;
        rd_addr_d         = rd_addr_q;
        dram_addr_d       = dram_addr_q;
        length_d          = length_q;
        multiline_d       = multiline_q;
        num_read_issued_d = num_read_issued_q;
        num_written_d     = num_written_q;
        num_acked_d       = num_acked_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        burst_left_d      = burst_left_q;
        op_done_d         = 1'b0;
        re_d              = 1'b0;
        raddr_d           = raddr_q;
        we_d              = 1'b0;
        wdata_d           = wdata_q;
        wlength_d         = wlength_q;
        ctrl_start_d      = 1'b0;
        ctrl_addr_d       = ctrl_addr_q;
        ctrl_reg4_d       = ctrl_reg4_q;
        pop               = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_start_i) begin
                    rd_addr_d         = regs_i[0][LOG2_MEMORY_SIZE-1:0];
                    dram_addr_d       = {in_addr_i[CLADDR_W-1:32], in_addr_i[31:0] + regs_i[1]};
                    length_d          = regs_i[2][30:0];
                    multiline_d       = regs_i[2][31];
                    num_read_issued_d = 32'd0;
                    num_written_d     = 32'd0;
                    num_acked_d       = 32'd0;
                    burst_left_d      = 2'd0;
                    if (regs_i[2][30:0] == 31'd0) begin
                        state_d = S_DONE;
                    end else if (in_trigger_dma_i) begin
                        state_d = S_TRIGGER;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_TRIGGER: begin
                if (dma_status_idle_i) begin
                    ctrl_start_d = 1'b1;
                    ctrl_addr_d  = dram_addr_q;
                    ctrl_reg4_d  = {multiline_q, length_q};
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                if ((num_read_issued_q < length_full) && (credit_used < {1'b0, STAGE_DEPTH})) begin
                    re_d              = 1'b1;
                    raddr_d           = rd_addr_q;
                    rd_addr_d         = rd_addr_q + LOG2_MEMORY_SIZE'(1);
                    num_read_issued_d = num_read_issued_q + 32'd1;
                end
                if (burst_left_q != 2'd0) begin
                    // a started burst runs to completion regardless of almostfull
                    pop          = 1'b1;
                    wlength_d    = 2'b11;
                    burst_left_d = burst_left_q - 2'd1;
                end else if (dma_status_active_i && !dma_almostfull_i && (num_written_q != length_full)) begin
                    if (multiline_q && (remaining >= 32'd4)) begin
                        // hold off until a whole burst is staged
                        if (stage_cnt_q >= BURST_LINES) begin
                            pop          = 1'b1;
                            wlength_d    = 2'b11;
                            burst_left_d = 2'd3;
                        end
                    end else if (stage_cnt_q != '0) begin
                        pop       = 1'b1;
                        wlength_d = 2'b00;
                    end
                end
                if (num_written_q == length_full) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (num_acked_q == length_full) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                op_done_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            we_d          = 1'b1;
            wdata_d       = fifo_mem_q[rd_ptr_q];
            rd_ptr_d      = rd_ptr_q + LOG2_STAGE_SIZE'(1);
            num_written_d = num_written_q + 32'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + LOG2_STAGE_SIZE'(1);
        end
        stage_cnt_d = stage_cnt_q + {{(SW-1){1'b0}}, push} - {{(SW-1){1'b0}}, pop};
        inflight_d  = inflight_q + {{(SW-1){1'b0}}, re_d} - {{(SW-1){1'b0}}, push};

        if (dma_wack_i && ((state_q == S_WRITE) || (state_q == S_DRAIN))) begin
            num_acked_d = num_acked_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        internal_reset_q <= reset_i;
    end

    always_ff @(posedge clk_i) begin
        if (internal_reset_q) begin
            state_q           <= S_IDLE;
            rd_addr_q         <= '0;
            dram_addr_q       <= '0;
            length_q          <= '0;
            multiline_q       <= 1'b0;
            num_read_issued_q <= '0;
            num_written_q     <= '0;
            num_acked_q       <= '0;
            inflight_q        <= '0;
            stage_cnt_q       <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            burst_left_q      <= '0;
            op_done_q         <= 1'b0;
            re_q              <= 1'b0;
            raddr_q           <= '0;
            we_q              <= 1'b0;
            wdata_q           <= '0;
            wlength_q         <= '0;
            ctrl_start_q      <= 1'b0;
            ctrl_addr_q       <= '0;
            ctrl_reg4_q       <= '0;
        end else begin
            state_q           <= state_d;
            rd_addr_q         <= rd_addr_d;
            dram_addr_q       <= dram_addr_d;
            length_q          <= length_d;
            multiline_q       <= multiline_d;
            num_read_issued_q <= num_read_issued_d;
            num_written_q     <= num_written_d;
            num_acked_q       <= num_acked_d;
            inflight_q        <= inflight_d;
            stage_cnt_q       <= stage_cnt_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            burst_left_q      <= burst_left_d;
            op_done_q         <= op_done_d;
            re_q              <= re_d;
            raddr_q           <= raddr_d;
            we_q              <= we_d;
            wdata_q           <= wdata_d;
            wlength_q         <= wlength_d;
            ctrl_start_q      <= ctrl_start_d;
            ctrl_addr_q       <= ctrl_addr_d;
            ctrl_reg4_q       <= ctrl_reg4_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= region_rdata_i;
        end
    end

    assign op_done_o        = op_done_q;
    assign region_re_o      = re_q;
    assign region_raddr_o   = raddr_q;
    assign dma_we_o         = we_q;
    assign dma_wdata_o      = wdata_q;
    assign dma_wlength_o    = wlength_q;
    assign dma_ctrl_start_o = ctrl_start_q;
    assign dma_ctrl_addr_o  = ctrl_addr_q;
    assign dma_ctrl_reg4_o  = ctrl_reg4_q;
    assign dma_ctrl_async_o = 1'b0;

endmodule

// File: tb/tb_glm_store.sv
`timescale 1ns/1ps
module tb_glm_store;
    localparam int LMS       = 10;
    localparam int MEM_LINES = 1 << LMS;
    localparam int CW        = 58;

    typedef struct {
        int            start;
        int            len;
        logic          ml;
        logic          trig;
        logic [31:0]   off;
        logic [CW-1:0] base;
        logic          af;
        int            idle_delay;
        logic          restart;
        logic [CW-1:0] exp_addr;
        int            exp_bursts;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           op_start = 1'b0;
    logic           op_done;
    logic           trig = 1'b0;
    logic [31:0]    regs [3];
    logic [CW-1:0]  in_addr = '0;
    logic           ctrl_start;
    logic [CW-1:0]  ctrl_addr;
    logic [31:0]    ctrl_reg4;
    logic           ctrl_async;
    logic           st_idle = 1'b1;
    logic           st_active = 1'b1;
    logic           we;
    logic [511:0]   wdata;
    logic [1:0]     wlength;
    logic           almostfull = 1'b0;
    logic           wack = 1'b0;
    logic           re;
    logic [LMS-1:0] raddr;
    logic [511:0]   rdata = '0;
    logic           rvalid = 1'b0;

    // driver-owned
    int   errors, checks, op_id;
    logic af_mode = 1'b0;
    // monitor-owned
    int   cyc, mon_op, re_cnt, we_cnt, max_occ, pending, acks, starts, dones, done_acks;
    logic [511:0]  obs_data [$];
    logic [1:0]    obs_wlen [$];
    int            obs_cyc [$];
    int            obs_raddr [$];
    logic [CW-1:0] seen_addr;
    logic [31:0]   seen_reg4;
    logic          seen_async;

    glm_store #(.LOG2_MEMORY_SIZE(LMS), .LOG2_STAGE_SIZE(4), .CLADDR_W(CW)) dut (
        .clk_i(clk), .reset_i(rst), .op_start_i(op_start), .op_done_o(op_done),
        .in_trigger_dma_i(trig), .regs_i(regs), .in_addr_i(in_addr),
        .dma_ctrl_start_o(ctrl_start), .dma_ctrl_addr_o(ctrl_addr),
        .dma_ctrl_reg4_o(ctrl_reg4), .dma_ctrl_async_o(ctrl_async),
        .dma_status_idle_i(st_idle), .dma_status_active_i(st_active),
        .dma_we_o(we), .dma_wdata_o(wdata), .dma_wlength_o(wlength),
        .dma_almostfull_i(almostfull), .dma_wack_i(wack),
        .region_re_o(re), .region_raddr_o(raddr),
        .region_rdata_i(rdata), .region_rvalid_i(rvalid)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [511:0] line_of(input int unsigned a);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(k) << 24) ^ 32'hA5A50000;
        return v;
    endfunction

    // Region BRAM (2-cycle latency), DMA write-side responder and observer.
    initial begin
        logic [511:0] p1_d, p2_d;
        logic         p1_v, p2_v;
        p1_d = '0; p2_d = '0; p1_v = 1'b0; p2_v = 1'b0;
        cyc = 0; mon_op = 0; re_cnt = 0; we_cnt = 0; max_occ = 0; pending = 0;
        acks = 0; starts = 0; dones = 0; done_acks = 0;
        seen_addr = '0; seen_reg4 = '0; seen_async = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_op != op_id) begin
                mon_op = op_id;
                obs_data.delete(); obs_wlen.delete(); obs_cyc.delete(); obs_raddr.delete();
                re_cnt = 0; we_cnt = 0; max_occ = 0; pending = 0; acks = 0;
                starts = 0; dones = 0; done_acks = 0;
            end
            rvalid = p2_v; rdata = p2_d;
            p2_v = p1_v; p2_d = p1_d;
            p1_v = re; p1_d = line_of(32'(raddr));
            if (re) begin re_cnt++; obs_raddr.push_back(int'(raddr)); end
            if (we) begin
                we_cnt++; pending++;
                obs_data.push_back(wdata); obs_wlen.push_back(wlength); obs_cyc.push_back(cyc);
            end
            if (re_cnt - we_cnt > max_occ) max_occ = re_cnt - we_cnt;
            if (ctrl_start) begin starts++; seen_addr = ctrl_addr; seen_reg4 = ctrl_reg4; seen_async = ctrl_async; end
            if (op_done) begin dones++; done_acks = acks; end
            if (pending > 0 && $urandom_range(0, 3) != 0) begin
                wack = 1'b1; pending--; acks++;
            end else begin
                wack = 1'b0;
            end
            almostfull = af_mode && (((cyc / 3) % 2) == 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got low word 0x%0h, expected low word 0x%0h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic run_op(input vec_t v);
        logic [511:0] exp_d [$];
        logic [1:0]   exp_w [$];
        int           exp_a [$];
        int           full, n, budget, nb;
        full = v.ml ? (v.len / 4) * 4 : 0;
        for (int i = 0; i < v.len; i++) begin
            exp_a.push_back((v.start + i) % MEM_LINES);
            exp_d.push_back(line_of(32'((v.start + i) % MEM_LINES)));
            exp_w.push_back(i < full ? 2'b11 : 2'b00);
        end
        regs[0] = 32'(v.start); regs[1] = v.off; regs[2] = {v.ml, 31'(v.len)};
        in_addr = v.base; trig = v.trig; af_mode = v.af; st_idle = (v.idle_delay == 0);
        op_id++;
        tick();
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        // anything latched later would show up as wrong data or extra beats
        regs[0] = 32'h3F0; regs[1] = 32'h55; regs[2] = 32'h0000_0007; in_addr = '1;
        n = 0; budget = v.len * 30 + 200;
        while (dones == 0 && n < budget) begin
            if (v.idle_delay != 0 && n == v.idle_delay) begin
                check("trigger_waits_start", 64'(starts), 64'd0);
                check("trigger_waits_re", 64'(re_cnt), 64'd0);
                st_idle = 1'b1;
            end
            op_start = (v.restart && n == 6);
            tick();
            n++;
        end
        op_start = 1'b0;
        check("op_done_seen", 64'(dones != 0), 64'd1);
        repeat (8) tick();
        check("op_done_count", 64'(dones), 64'd1);
        check("acks_before_done", 64'(done_acks), 64'(v.len));
        check("start_count", 64'(starts), 64'(v.trig));
        if (v.trig) begin
            check("ctrl_addr", 64'(seen_addr), 64'(v.exp_addr));
            check("ctrl_reg4", 64'(seen_reg4), 64'({v.ml, 31'(v.len)}));
            check("ctrl_async", 64'(seen_async), 64'd0);
        end
        check("read_count", 64'(re_cnt), 64'(v.len));
        check("beat_count", 64'(obs_data.size()), 64'(v.len));
        nb = 0;
        for (int i = 0; i < v.len && i < obs_data.size(); i++) begin
            check_line($sformatf("beat_data[%0d]", i), obs_data[i], exp_d[i]);
            check($sformatf("beat_wlength[%0d]", i), 64'(obs_wlen[i]), 64'(exp_w[i]));
            if (obs_wlen[i] == 2'b11) nb++;
            if (exp_w[i] == 2'b11 && (i % 4) != 0)
                check($sformatf("burst_contiguous[%0d]", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
        end
        for (int i = 0; i < v.len && i < obs_raddr.size(); i++)
            check($sformatf("raddr[%0d]", i), 64'(obs_raddr[i]), 64'(exp_a[i]));
        check("burst_count", 64'(nb / 4), 64'(v.exp_bursts));
        checks++;
        if (max_occ > 16) begin
            errors++;
            $display("FAIL stage_bound: got %0d lines staged+in flight, limit 16", max_occ);
        end
    endtask

    initial begin
        vec_t vecs [7];
        vec_t rv;
        int   n;
        errors = 0; checks = 0; op_id = 0;
        regs[0] = '0; regs[1] = '0; regs[2] = '0;
        //           start len  ml    trig  off            base                 af    idle rst   exp_addr             bursts
        vecs[0] = '{5,    1,  1'b0, 1'b1, 32'd0,         58'h100,             1'b0, 0,   1'b0, 58'h100,             0};
        vecs[1] = '{32,   8,  1'b1, 1'b1, 32'd4,         58'h1000,            1'b0, 0,   1'b0, 58'h1004,            2};
        vecs[2] = '{100,  6,  1'b1, 1'b0, 32'd0,         58'h0,               1'b0, 0,   1'b0, 58'h0,               1};
        vecs[3] = '{300,  40, 1'b0, 1'b1, 32'h10,        58'h2_0000_0000,     1'b1, 0,   1'b0, 58'h2_0000_0010,     0};
        vecs[4] = '{1022, 4,  1'b0, 1'b0, 32'd0,         58'h0,               1'b0, 0,   1'b0, 58'h0,               0};
        vecs[5] = '{7,    13, 1'b1, 1'b1, 32'hFFFF_FFFF, 58'h5_0000_0002,     1'b0, 8,   1'b1, 58'h5_0000_0001,     3};
        vecs[6] = '{50,   40, 1'b1, 1'b0, 32'd0,         58'h0,               1'b1, 0,   1'b1, 58'h0,               10};

        rst = 1'b1;
        repeat (5) tick();
        check("reset_op_done", 64'(op_done), 64'd0);
        check("reset_we", 64'(we), 64'd0);
        check("reset_re", 64'(re), 64'd0);
        check("reset_ctrl_start", 64'(ctrl_start), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // zero length, no trigger: IDLE -> DONE -> pulse
        regs[0] = 32'd9; regs[1] = 32'd0; regs[2] = 32'd0; trig = 1'b0; af_mode = 1'b0;
        op_id++;
        tick();
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        check("zero_len_done_c1", 64'(op_done), 64'd0);
        tick();
        check("zero_len_done_c2", 64'(op_done), 64'd1);
        tick();
        check("zero_len_done_c3", 64'(op_done), 64'd0);
        repeat (4) tick();
        check("zero_len_reads", 64'(re_cnt), 64'd0);
        check("zero_len_beats", 64'(obs_data.size()), 64'd0);

        // reset in the middle of a 20-line write
        regs[0] = 32'd200; regs[1] = 32'd0; regs[2] = 32'd20; trig = 1'b1; in_addr = 58'h40;
        op_id++;
        tick();
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        n = 0;
        while (obs_data.size() < 5 && n < 500) begin tick(); n++; end
        check("reset_reach_line5", 64'(obs_data.size() >= 5), 64'd1);
        rst = 1'b1;
        tick(); tick();
        check("midreset_we", 64'(we), 64'd0);
        check("midreset_re", 64'(re), 64'd0);
        check("midreset_ctrl_start", 64'(ctrl_start), 64'd0);
        check("midreset_op_done", 64'(op_done), 64'd0);
        repeat (4) tick();
        check("midreset_no_done", 64'(dones), 64'd0);
        op_id++;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("post_reset_no_done", 64'(dones), 64'd0);
        check("post_reset_no_we", 64'(obs_data.size()), 64'd0);
        check("post_reset_no_re", 64'(re_cnt), 64'd0);
        rv = '{400, 2, 1'b0, 1'b1, 32'd3, 58'h80, 1'b0, 0, 1'b0, 58'h83, 0};
        run_op(rv);

        // randomized operations against the model
        for (int r = 0; r < 8; r++) begin
            rv.start      = int'($urandom_range(0, MEM_LINES - 1));
            rv.len        = int'($urandom_range(1, 40));
            rv.ml         = 1'($urandom_range(0, 1));
            rv.trig       = 1'($urandom_range(0, 1));
            rv.off        = $urandom;
            rv.base       = {26'($urandom), $urandom};
            rv.af         = 1'($urandom_range(0, 1));
            rv.idle_delay = 0;
            rv.restart    = 1'($urandom_range(0, 1));
            rv.exp_addr   = {rv.base[CW-1:32], rv.base[31:0] + rv.off};
            rv.exp_bursts = rv.ml ? rv.len / 4 : 0;
            run_op(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
